alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one 32-bit ALU between N_REQ requesters, such as a fetch/PC-increment unit and the execute stage. A round-robin arbiter picks one request and captures its operands and control code. The ALU evaluates the captured values, and the registered result and zero flag are returned to the winning requester with a valid/ready handshake. The block owns the ALU instance and sits between the requesters and the register-write path.

Parameters:
N_REQ, 2, number of requesters (≥2)
DATA_W, 32, operand/result width
ID_W, $clog2(N_REQ), requester index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_op1  in  N_REQ*DATA_W  packed op1, requester i at [i*DATA_W +: DATA_W]
req_op2  in  N_REQ*DATA_W  packed op2, same packing
req_ctrl  in  N_REQ*3  packed ALU control, 000 ADD, 001 SUB, others yield result 0
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_result  out  DATA_W  registered ALU result
rsp_zero  out  1  registered (result == 0)
rsp_id  out  ID_W  index of the requester that owns the result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, captured operands=0.
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit scanning from rr_ptr upward, wrapping mod N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: capture op1/op2/ctrl of the winner, set rsp_id=winner and rr_ptr=(winner+1) mod N_REQ, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC:
  - The ALU evaluates the captured operands.
  - rsp_result and rsp_zero are registered at the edge, rsp_valid is set to 1, and the FSM goes to RESP.
- RESP:
  - rsp_valid=1; rsp_result, rsp_zero and rsp_id stay stable until the handshake.
  - When rsp_valid && rsp_ready: rsp_valid=0, go to IDLE.
- req_ready is 0 in EXEC and RESP regardless of req_valid.
- Latency:
  - Accept edge T gives rsp_valid=1 after edge T+1.
  - Minimum 3 cycles per operation: accept, execute, respond with immediate rsp_ready. There is no overlap.
- Arithmetic:
  - Results wrap mod 2^DATA_W; no carry or overflow outputs.
  - Unsupported ctrl gives result=0 and zero=1.
- Boundary conditions:
  - A requester may drop req_valid before being granted; it is simply not selected.
  - A requester that is not granted keeps its request pending, with no starvation: it wins within N_REQ grants.
  - If all requesters are valid continuously, grants rotate 0,1,…,N_REQ-1,0.
  - If rsp_ready is held high when entering RESP, RESP lasts exactly one cycle.
  - If rsp_ready is low, RESP holds indefinitely and new requests are not accepted.
  - Reset mid-operation abandons the operation; no response is issued.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU control localparams (ALU_ADD=3'b000, ALU_SUB=3'b001, width 3);
  - the enum arb_state_t {IDLE, EXEC, RESP}.
- Sub-module: the team's existing combinational ALU, instantiated once.
- Round-robin selection stays inline as a function.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, no requests. Expect all outputs 0, busy=0, req_ready=0.
- Single ADD:
  - Stimulus: req 0, op1=5, op2=7, ctrl=000, rsp_ready=1.
  - Expect: req_ready[0]=1 for one cycle; rsp_valid 2 cycles after accept with result=12, zero=0, id=0.
- SUB to zero and wrap:
  - Stimulus: req 1, op1=9, op2=9, ctrl=001. Expect result=0, zero=1, id=1.
  - Stimulus: op1=0, op2=1, SUB. Expect result=32'hFFFF_FFFF, zero=0.
- Round-robin fairness: both requesters valid for 4 ops. Expect grant order 0,1,0,1 and rsp_id matching each requester's operands.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles during RESP while req_valid[0] is high.
  - Expect: rsp_result/id stable, req_ready=0 throughout; the next grant comes only after the handshake.
- Unsupported ctrl and mid-op reset:
  - Stimulus: ctrl=111. Expect result=0, zero=1.
  - Stimulus: assert rst_n=0 during EXEC. Expect rsp_valid=0 immediately, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU arbiter slice:
//   - ALU control encodings (3-bit control word)
//   - arbiter FSM state type
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage : alu_pkg

// File: rtl/alu_share_arbiter_alu.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_alu
// Purely combinational ALU. ADD and SUB wrap modulo 2^DATA_W; any other
// control code produces a zero result.
//
// Ports:
//   op1    in   DATA_W      first operand
//   op2    in   DATA_W      second operand
//   ctrl   in   ALU_CTRL_W  operation select
//   result out  DATA_W      op1 (+|-) op2, or 0 for unsupported codes
//   zero   out  1           result == 0
// -----------------------------------------------------------------------------
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]     op1,
    input  logic [DATA_W-1:0]     op2,
    input  logic [ALU_CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0]     result,
    output logic                  zero
);

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        result = '0;
        case (ctrl)
            ALU_ADD: result = op1 + op2;
            ALU_SUB: result = op1 - op2;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule : alu_share_arbiter_alu

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU between N_REQ requesters. In IDLE a round-robin pick selects
// one valid requester, grants it combinationally through req_ready and
// captures its operands. EXEC registers the ALU result; RESP presents it on a
// valid/ready response port tagged with the winner's index. One operation is
// in flight at a time.
//
// Ports:
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   req_valid  in   N_REQ         per-requester request valid
//   req_ready  out  N_REQ         per-requester grant, one-hot or zero
//   req_op1    in   N_REQ*DATA_W  packed op1, requester i at [i*DATA_W +: DATA_W]
//   req_op2    in   N_REQ*DATA_W  packed op2, same packing
//   req_ctrl   in   N_REQ*3       packed ALU control
//   rsp_valid  out  1             result valid
//   rsp_ready  in   1             consumer accepts result
//   rsp_result out  DATA_W        registered ALU result
//   rsp_zero   out  1             registered (result == 0)
//   rsp_id     out  ID_W          owner of the current result
//   busy       out  1             FSM not in IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ*DATA_W-1:0]        req_op1,
    input  logic [N_REQ*DATA_W-1:0]        req_op2,
    input  logic [N_REQ*ALU_CTRL_W-1:0]    req_ctrl,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_W-1:0]              rsp_result,
    output logic                           rsp_zero,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           busy
);

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] win;
        logic            found;
        int              idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        return win;
    endfunction

    arb_state_t              state_q,      state_d;
    logic [ID_W-1:0]         rr_ptr_q,     rr_ptr_d;
    logic [DATA_W-1:0]       op1_q,        op1_d;
    logic [DATA_W-1:0]       op2_q,        op2_d;
    logic [ALU_CTRL_W-1:0]   ctrl_q,       ctrl_d;
    logic [ID_W-1:0]         rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0]       rsp_result_q, rsp_result_d;
    logic                    rsp_zero_q,   rsp_zero_d;
    logic                    rsp_valid_q,  rsp_valid_d;

    logic [ID_W-1:0]         winner;
    logic [DATA_W-1:0]       alu_result;
    logic                    alu_zero;

    alu_share_arbiter_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op1    (op1_q),
        .op2    (op2_q),
        .ctrl   (ctrl_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        ctrl_d       = ctrl_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_valid_d  = rsp_valid_q;
        req_ready    = '0;
        winner       = rr_pick(req_valid, rr_ptr_q);

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[winner] = 1'b1;
                    op1_d    = req_op1[int'(winner)*DATA_W +: DATA_W];
                    op2_d    = req_op2[int'(winner)*DATA_W +: DATA_W];
                    ctrl_d   = req_ctrl[int'(winner)*ALU_CTRL_W +: ALU_CTRL_W];
                    rsp_id_d = winner;
                    // Pointer moves just past the winner so it has lowest
                    // priority next time; this bounds any wait to N_REQ grants.
                    rr_ptr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the captured operand registers are reset as well, so the
            // ALU never evaluates X after reset and outputs are deterministic.
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            ctrl_q       <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            ctrl_q       <= ctrl_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = (state_q != IDLE);

endmodule : alu_share_arbiter

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed stimulus with hand-computed expectations. Each issued request
// pushes its expected grant vector and response into queues; a monitor on the
// falling edge pops and compares whenever the DUT grants or hands over a
// response.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int ID_W   = 1;

    typedef struct {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [ID_W-1:0]   id;
    } rsp_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*DATA_W-1:0]   req_op1;
    logic [N_REQ*DATA_W-1:0]   req_op2;
    logic [N_REQ*3-1:0]        req_ctrl;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_zero;
    logic [ID_W-1:0]           rsp_id;
    logic                      busy;

    int errors = 0;
    int checks = 0;

    logic [N_REQ-1:0] exp_grant[$];
    rsp_t             exp_rsp[$];

    alu_share_arbiter #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c);
        req_op1[id*DATA_W +: DATA_W] = a;
        req_op2[id*DATA_W +: DATA_W] = b;
        req_ctrl[id*3 +: 3]          = c;
        req_valid[id]                = 1'b1;
    endtask

    task automatic expect_op(input int id, input logic [31:0] res, input logic zero,
                             input bit has_rsp);
        rsp_t r;
        exp_grant.push_back(N_REQ'(1 << id));
        if (has_rsp) begin
            r.result = res;
            r.zero   = zero;
            r.id     = ID_W'(id);
            exp_rsp.push_back(r);
        end
    endtask

    // Waits (bounded) until requester id is granted, returns just after the
    // accepting edge.
    task automatic wait_grant(input int id);
        bit got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
        end
        check($sformatf("grant_wait_req%0d", id), 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) got = 1'b1;
        end
        check("idle_wait", 32'(got), 32'd1);
    endtask

    // Monitor: grants and response handshakes are compared against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) begin
                if (exp_grant.size() == 0)
                    check("unexpected_grant", 32'(req_ready), 32'd0);
                else
                    check("grant_vector", 32'(req_ready), 32'(exp_grant.pop_front()));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    check("rsp_result", rsp_result, e.result);
                    check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;

        // ---- reset, then idle ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd0);

        // ---- single ADD with latency check: 5 + 7 = 12 ----
        @(posedge clk); #1;
        expect_op(0, 32'd12, 1'b0, 1'b1);
        set_req(0, 32'd5, 32'd7, 3'b000);
        wait_grant(0);
        req_valid = '0;
        @(negedge clk);
        check("add_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("add_exec_busy", 32'(busy), 32'd1);
        check("add_exec_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("add_resp_rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("add_resp_one_cycle", 32'(rsp_valid), 32'd0);
        check("add_back_idle", 32'(busy), 32'd0);

        // ---- SUB to zero, then SUB wrap ----
        @(posedge clk); #1;
        expect_op(1, 32'd0, 1'b1, 1'b1);
        set_req(1, 32'd9, 32'd9, 3'b001);
        wait_grant(1);
        req_valid = '0;
        wait_idle();
        @(posedge clk); #1;
        expect_op(1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        set_req(1, 32'd0, 32'd1, 3'b001);
        wait_grant(1);
        req_valid = '0;
        wait_idle();

        // ---- round robin: both valid, grants 0,1,0,1 ----
        @(posedge clk); #1;
        expect_op(0, 32'd123, 1'b0, 1'b1);
        expect_op(1, 32'd999, 1'b0, 1'b1);
        expect_op(0, 32'hFFFF_FFF6, 1'b0, 1'b1);
        expect_op(1, 32'd0, 1'b1, 1'b1);
        set_req(0, 32'd100, 32'd23, 3'b000);
        set_req(1, 32'd1000, 32'd1, 3'b001);
        wait_grant(0);
        set_req(0, 32'd50, 32'd60, 3'b001);
        wait_grant(1);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 3'b000);
        wait_grant(0);
        req_valid[0] = 1'b0;
        wait_grant(1);
        req_valid[1] = 1'b0;
        wait_idle();

        // ---- backpressure: rsp_ready low for 5 cycles in RESP ----
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        expect_op(0, 32'd5, 1'b0, 1'b1);
        expect_op(0, 32'd6, 1'b0, 1'b1);
        set_req(0, 32'd2, 32'd3, 3'b000);
        wait_grant(0);
        set_req(0, 32'd10, 32'd4, 3'b001);
        begin
            bit got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (rsp_valid) got = 1'b1;
            end
            check("bp_rsp_valid_wait", 32'(got), 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_result", rsp_result, 32'd5);
            check("bp_rsp_id", 32'(rsp_id), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_grant(0);
        req_valid = '0;
        wait_idle();

        // ---- unsupported control codes ----
        @(posedge clk); #1;
        expect_op(1, 32'd0, 1'b1, 1'b1);
        set_req(1, 32'd123, 32'd456, 3'b111);
        wait_grant(1);
        req_valid = '0;
        wait_idle();
        @(posedge clk); #1;
        expect_op(0, 32'd0, 1'b1, 1'b1);
        set_req(0, 32'd5, 32'd5, 3'b010);
        wait_grant(0);
        req_valid = '0;
        wait_idle();

        // ---- reset during EXEC abandons the op and clears rr_ptr ----
        @(posedge clk); #1;
        expect_op(0, 32'd0, 1'b0, 1'b0);
        set_req(0, 32'd1, 32'd1, 3'b000);
        wait_grant(0);
        req_valid = '0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        expect_op(0, 32'd38, 1'b0, 1'b1);
        expect_op(1, 32'd0, 1'b1, 1'b1);
        set_req(0, 32'd40, 32'd2, 3'b001);
        set_req(1, 32'd0, 32'd0, 3'b000);
        wait_grant(0);
        req_valid[0] = 1'b0;
        wait_grant(1);
        req_valid[1] = 1'b0;
        wait_idle();

        // ---- every expectation consumed ----
        check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_share_arbiter
